// File: rtl/aes_cipher_ctrl.sv
// aes_cipher_ctrl
//   Sequencer and round-key store for an iterative AES "cipher" core.
//   The host loads up to 15 round keys, then commits them with key_cfg_valid
//   and key_size. One plaintext block at a time is accepted over in_valid/in_ready.
//   The core is then launched with a one-cycle c_en pulse. Round keys are served
//   at c_round_key_no with one cycle of SRAM-style latency, and the ciphertext
//   is returned over out_valid/out_ready.
//
// Optional feature macro: AES_CTRL_STATS_EN (adds blk_count / stall_count).
//
// Ports:
//   clk, reset          clock, synchronous active-high reset
//   key_wr_en/addr/data round-key write port (honoured only while IDLE)
//   key_cfg_valid       key set complete; latches key_size (0:10 rounds, 1:14 rounds)
//   key_ready, busy     status
//   in_valid/ready/data plaintext stream
//   out_valid/ready/data ciphertext stream
//   c_en, c_rounds_total, c_plaintext, c_key          to core
//   c_round_key_no, c_en_o, c_ciphertext              from core
//   blk_count, stall_count (AES_CTRL_STATS_EN only)   statistics
module aes_cipher_ctrl #(
   parameter int BLK_W     = 128,
   parameter int NR_W      = 4,
   parameter int KEY_DEPTH = 15
`ifdef AES_CTRL_STATS_EN
   ,
   parameter int CNT_W     = 32
`endif
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             key_wr_en,
   input  logic [NR_W-1:0]  key_wr_addr,
   input  logic [BLK_W-1:0] key_wr_data,
   input  logic             key_cfg_valid,
   input  logic             key_size,
   output logic             key_ready,
   output logic             busy,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [BLK_W-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [BLK_W-1:0] out_data,
   output logic             c_en,
   output logic [NR_W-1:0]  c_rounds_total,
   output logic [BLK_W-1:0] c_plaintext,
   output logic [BLK_W-1:0] c_key,
   input  logic [NR_W-1:0]  c_round_key_no,
   input  logic             c_en_o,
   input  logic [BLK_W-1:0] c_ciphertext
`ifdef AES_CTRL_STATS_EN
   ,
   output logic [CNT_W-1:0] blk_count,
   output logic [CNT_W-1:0] stall_count
`endif
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_START = 2'd1;
   localparam logic [1:0] ST_RUN   = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   localparam logic [NR_W-1:0] LAST_IDX = NR_W'(KEY_DEPTH - 1);
   localparam logic [NR_W-1:0] NR_128   = NR_W'(10);
   localparam logic [NR_W-1:0] NR_256   = NR_W'(14);

   logic [1:0]       state_r;
   logic [NR_W-1:0]  rounds_r;
   logic [BLK_W-1:0] key_mem [KEY_DEPTH];
   logic             idle_s;
   logic             key_wr_acc_s;
   logic             in_hs_s;
   logic             out_hs_s;

   assign idle_s       = (state_r == ST_IDLE);
   // Index 15 is outside the store and never written.
   assign key_wr_acc_s = key_wr_en && idle_s && (key_wr_addr <= LAST_IDX);
   assign in_ready     = idle_s && key_ready && !out_valid;
   assign in_hs_s      = in_valid && in_ready;
   assign out_hs_s     = out_valid && out_ready;
   assign busy         = !idle_s;

   // Round-key storage; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (key_wr_acc_s) begin
         key_mem[key_wr_addr] <= key_wr_data;
      end
   end

   // Registered key read toward the core; the out-of-range index reads as zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         c_key <= '0;
      end else if (c_round_key_no <= LAST_IDX) begin
         c_key <= key_mem[c_round_key_no];
      end else begin
         c_key <= '0;
      end
   end

   // Key commit: a config pulse wins over a simultaneous write, so the key set ends ready.
   always_ff @(posedge clk) begin
      if (reset) begin
         key_ready <= 1'b0;
         rounds_r  <= '0;
      end else if (idle_s && key_cfg_valid) begin
         key_ready <= 1'b1;
         rounds_r  <= key_size ? NR_256 : NR_128;
      end else if (key_wr_acc_s) begin
         key_ready <= 1'b0;
      end
   end

   // Block sequencer: accept, launch core, wait for done, hold result until taken.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r        <= ST_IDLE;
         c_en           <= 1'b0;
         c_rounds_total <= '0;
         c_plaintext    <= '0;
         out_valid      <= 1'b0;
         out_data       <= '0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (in_hs_s) begin
                  c_plaintext    <= in_data;
                  c_rounds_total <= rounds_r;
                  c_en           <= 1'b1;   // high for the whole START cycle
                  state_r        <= ST_START;
               end
            end
            ST_START: begin
               c_en    <= 1'b0;
               state_r <= ST_RUN;
            end
            ST_RUN: begin
               if (c_en_o) begin
                  out_data  <= c_ciphertext;
                  out_valid <= 1'b1;
                  state_r   <= ST_DONE;
               end
            end
            ST_DONE: begin
               // Late c_en_o cycles land here and are ignored.
               if (out_hs_s) begin
                  out_valid <= 1'b0;
                  state_r   <= ST_IDLE;
               end
            end
            default: begin
               c_en      <= 1'b0;
               out_valid <= 1'b0;
               state_r   <= ST_IDLE;
            end
         endcase
      end
   end

`ifdef AES_CTRL_STATS_EN
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   // Completed-block counter (wraps) and output-stall counter (saturates).
   always_ff @(posedge clk) begin
      if (reset) begin
         blk_count   <= '0;
         stall_count <= '0;
      end else begin
         if (out_hs_s) begin
            blk_count <= blk_count + CNT_W'(1);
         end
         if ((state_r == ST_DONE) && !out_ready && (stall_count != CNT_MAX)) begin
            stall_count <= stall_count + CNT_W'(1);
         end
      end
   end
`endif

endmodule

// File: tb/tb_aes_cipher_ctrl.sv
// Bench for aes_cipher_ctrl. A small stand-in core walks round keys 0..rounds
// through c_round_key_no / c_key and returns plaintext XOR all served keys.
// Expected results are computed from the bench's own shadow of the key store.
module tb_aes_cipher_ctrl;
   logic         clk = 1'b0;
   logic         reset;
   logic         key_wr_en, key_cfg_valid, key_size;
   logic [3:0]   key_wr_addr;
   logic [127:0] key_wr_data;
   logic         key_ready, busy, in_valid, in_ready, out_valid, out_ready;
   logic [127:0] in_data, out_data, c_plaintext, c_key, c_ciphertext;
   logic         c_en, c_en_o;
   logic [3:0]   c_rounds_total, c_round_key_no;
`ifdef AES_CTRL_STATS_EN
   logic [31:0]  blk_count, stall_count;
`endif

   aes_cipher_ctrl dut (
      .clk(clk), .reset(reset),
      .key_wr_en(key_wr_en), .key_wr_addr(key_wr_addr), .key_wr_data(key_wr_data),
      .key_cfg_valid(key_cfg_valid), .key_size(key_size),
      .key_ready(key_ready), .busy(busy),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .c_en(c_en), .c_rounds_total(c_rounds_total), .c_plaintext(c_plaintext),
      .c_key(c_key), .c_round_key_no(c_round_key_no), .c_en_o(c_en_o),
      .c_ciphertext(c_ciphertext)
`ifdef AES_CTRL_STATS_EN
      , .blk_count(blk_count), .stall_count(stall_count)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {logic [127:0] pt; logic [127:0] ct; logic [3:0] rounds;} exp_t;
   typedef struct {logic ks; logic [127:0] pt; logic [3:0] rounds; int dlen;} vec_t;

   exp_t         sb[$];
   vec_t         vt[4];
   logic [127:0] sk[15];
   logic [127:0] k128[15];
   logic [127:0] k256[15];
   int           n_vec = 0;
   int           n_err = 0;
   int           n_blk = 0;
   int           done_len = 1;
   logic [3:0]   idle_rkn = 4'd0;

   localparam logic [127:0] PT1 = 128'hffeeddccbbaa99887766554433221100;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail(input string nm);
      n_vec++;
      n_err++;
      $display("FAIL %s", nm);
   endtask

   function automatic logic [127:0] model_ct(input logic [127:0] pt, input logic [3:0] r);
      logic [127:0] acc;
      acc = pt;
      for (int i = 0; i <= int'(r); i++) acc ^= sk[i];
      return acc;
   endfunction

   // Stand-in iterative core: two cycles per round key (present index, consume key).
   logic         core_act, phase;
   logic [127:0] acc;
   logic [3:0]   tot;
   int           done_cnt;
   always @(posedge clk) begin
      if (reset) begin
         core_act <= 1'b0; c_en_o <= 1'b0; done_cnt <= 0;
         c_round_key_no <= idle_rkn; c_ciphertext <= '0; phase <= 1'b0;
      end else begin
         if (done_cnt == 1) begin
            c_en_o <= 1'b0; done_cnt <= 0;
         end else if (done_cnt > 1) begin
            done_cnt <= done_cnt - 1;
         end
         if (c_en) begin
            core_act <= 1'b1; acc <= c_plaintext; tot <= c_rounds_total;
            c_round_key_no <= 4'd0; phase <= 1'b0;
         end else if (core_act) begin
            if (!phase) begin
               phase <= 1'b1;
            end else begin
               phase <= 1'b0;
               if (c_round_key_no == tot) begin
                  core_act <= 1'b0; c_ciphertext <= acc ^ c_key; c_en_o <= 1'b1;
                  done_cnt <= done_len; c_round_key_no <= idle_rkn;
               end else begin
                  acc <= acc ^ c_key; c_round_key_no <= c_round_key_no + 4'd1;
               end
            end
         end else begin
            c_round_key_no <= idle_rkn;
         end
      end
   end

   // Scoreboard monitor: launch parameters at c_en, result at output handshake.
   logic prev_c_en = 1'b0;
   always @(negedge clk) begin
      exp_t e;
      if (!reset) begin
         if (c_en) begin
            chk("c_en_single", prev_c_en, 1'b0);
            if (sb.size() == 0) fail("c_en_unexpected");
            else begin
               chk("c_rounds_total", c_rounds_total, sb[0].rounds);
               chk("c_plaintext", c_plaintext, sb[0].pt);
            end
         end
         if (out_valid && out_ready) begin
            n_blk++;
            if (sb.size() == 0) fail("out_unexpected");
            else begin
               e = sb.pop_front();
               chk("out_data", out_data, e.ct);
            end
         end
      end
      prev_c_en <= c_en && !reset;
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic write_key(input logic [3:0] a, input logic [127:0] d);
      key_wr_en = 1'b1; key_wr_addr = a; key_wr_data = d;
      tick();
      key_wr_en = 1'b0;
      if (a < 4'd15) sk[a] = d;
   endtask

   task automatic cfg(input logic ks);
      key_cfg_valid = 1'b1; key_size = ks;
      tick();
      key_cfg_valid = 1'b0;
      chk("key_ready_cfg", key_ready, 1'b1);
   endtask

   task automatic load_keys(input logic ks);
      for (int i = 0; i < (ks ? 15 : 11); i++)
         write_key(4'(i), ks ? k256[i] : k128[i]);
      cfg(ks);
   endtask

   task automatic push_exp(input logic [127:0] pt, input logic [3:0] r);
      exp_t e;
      e.pt = pt; e.rounds = r; e.ct = model_ct(pt, r);
      sb.push_back(e);
   endtask

   task automatic send(input logic [127:0] pt, input logic [3:0] r);
      logic ok;
      push_exp(pt, r);
      in_valid = 1'b1; in_data = pt; ok = 1'b0;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         if (in_ready) ok = 1'b1;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (!ok) begin fail("send_timeout"); sb.delete(); end
   endtask

   task automatic drain();
      for (int i = 0; i < 500 && sb.size() != 0; i++) @(negedge clk);
      if (sb.size() != 0) begin fail("drain_timeout"); sb.delete(); end
      tick();
   endtask

   initial begin
      #400000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] cap;
      logic         bad;
      reset = 1'b1; key_wr_en = 1'b0; key_cfg_valid = 1'b0; key_size = 1'b0;
      key_wr_addr = 4'd0; key_wr_data = '0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b1;
      for (int i = 0; i < 15; i++) begin
         k128[i] = {$urandom, $urandom, $urandom, $urandom};
         k256[i] = {$urandom, $urandom, $urandom, $urandom};
         sk[i]   = '0;
      end
      k128[0] = 128'h0f0e0d0c0b0a09080706050403020100;
      k256[0] = 128'h0f0e0d0c0b0a09080706050403020100;
      k256[1] = 128'h1f1e1d1c1b1a19181716151413121110;
      vt[0] = '{1'b0, PT1, 4'd10, 1};
      vt[1] = '{1'b1, PT1, 4'd14, 3};
      vt[2] = '{1'b0, 128'h0123456789abcdef0011223344556677, 4'd10, 2};
      vt[3] = '{1'b1, 128'hdeadbeefcafef00d5555aaaa12345678, 4'd14, 1};

      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ctrl", {out_valid, c_en, key_ready, busy, in_ready}, 5'd0);
      chk("rst_data", out_data | c_plaintext | c_key, 128'd0);
      chk("rst_rounds", c_rounds_total, 4'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      tick();

      // Table-driven blocks: 128/256-bit key sets, varying core done-pulse length.
      for (int v = 0; v < 4; v++) begin
         load_keys(vt[v].ks);
         done_len = vt[v].dlen;
         send(vt[v].pt, vt[v].rounds);
         drain();
      end
      done_len = 1;

      // Key read port: index 15 reads zero, a valid index reads its key.
      idle_rkn = 4'd15; tick(); tick();
      chk("c_key_oob", c_key, 128'd0);
      idle_rkn = 4'd2; tick(); tick();
      chk("c_key_idx2", c_key, sk[2]);
      idle_rkn = 4'd0;
      write_key(4'd15, 128'h1234);
      chk("key_ready_addr15", key_ready, 1'b1);

      // Backpressure: result held, no second block accepted, then back-to-back.
      load_keys(1'b0);
      out_ready = 1'b0;
      send(PT1, 4'd10);
      for (int i = 0; i < 500 && !out_valid; i++) @(negedge clk);
      chk("bp_out_valid", out_valid, 1'b1);
      cap = out_data;
      in_valid = 1'b1; in_data = 128'h00112233445566778899aabbccddeeff;
      bad = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (!out_valid || out_data !== cap || in_ready || !busy) bad = 1'b1;
      end
      chk("bp_hold", bad, 1'b0);
      push_exp(in_data, 4'd10);
      @(posedge clk); #1;
      out_ready = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_done", in_ready, 1'b0);
      @(negedge clk);
      chk("b2b_in_ready", in_ready, 1'b1);
      @(posedge clk); #1;
      in_valid = 1'b0;
      drain();

      // Key writes during RUN are dropped.
      send(PT1, 4'd10);
      tick();
      key_wr_en = 1'b1; key_wr_addr = 4'd10; key_wr_data = {4{32'hbad0bad0}};
      tick();
      key_wr_addr = 4'd9;
      tick();
      key_wr_en = 1'b0;
      drain();
      chk("key_ready_after_run_wr", key_ready, 1'b1);
      idle_rkn = 4'd10; tick(); tick();
      chk("key10_kept", c_key, sk[10]);
      idle_rkn = 4'd0;

      // Key write after config blocks input until re-commit.
      write_key(4'd3, sk[3]);
      chk("key_ready_cleared", key_ready, 1'b0);
      in_valid = 1'b1; in_data = PT1; bad = 1'b0;
      repeat (5) begin
         @(negedge clk);
         if (in_ready) bad = 1'b1;
      end
      chk("in_ready_blocked", bad, 1'b0);
      @(posedge clk); #1;
      key_wr_en = 1'b1; key_wr_addr = 4'd4; key_wr_data = sk[4];
      key_cfg_valid = 1'b1; key_size = 1'b0;
      tick();
      in_valid = 1'b0; key_wr_en = 1'b0; key_cfg_valid = 1'b0;
      chk("key_ready_wr_cfg", key_ready, 1'b1);
      send(PT1, 4'd10);
      drain();

      // Reset three cycles into RUN, then recommit and rerun vector 1.
      send(PT1, 4'd10);
      tick();
      repeat (3) tick();
      reset = 1'b1;
      tick();
      chk("midrst_status", {busy, out_valid, key_ready, c_en}, 4'd0);
      sb.delete();
      n_blk = 0;
      reset = 1'b0;
      tick();
      cfg(1'b0);
      send(PT1, 4'd10);
      drain();

`ifdef AES_CTRL_STATS_EN
      chk("blk_count", blk_count, 128'(n_blk));
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/aes_cipher_ctrl.md
Name: aes_cipher_ctrl

Overview:
Sequencer and round-key store for the iterative `cipher` core. Holds up to 15 round keys loaded by the host. Accepts one plaintext block at a time over a valid/ready stream and launches the core with the configured round count. Serves round keys at the core's `round_key_no` with one-cycle SRAM latency, then returns the ciphertext over a valid/ready output stream.

Parameters:
BLK_W, 128, block and round-key width (`BLK_S`/`ROUND_KEY_BITS`)
NR_W, 4, width of round count and key index (`Nb`)
KEY_DEPTH, 15, round-key entries (`Nr_256`+1)
CNT_W, 32, statistics counter width (optional feature only)

Ports:
clk  in  1  system clock; all logic on posedge
reset  in  1  synchronous, active-high
key_wr_en  in  1  write round key; honoured only in IDLE
key_wr_addr  in  NR_W  round-key index 0..14; 15 ignored
key_wr_data  in  BLK_W  round-key value
key_cfg_valid  in  1  pulse: key set complete, latch key_size
key_size  in  1  0 = 128-bit (`Nr_128`=10), 1 = 256-bit (`Nr_256`=14)
key_ready  out  1  keys committed, blocks may be accepted
busy  out  1  high outside IDLE
in_valid  in  1  plaintext available
in_ready  out  1  controller accepts plaintext
in_data  in  BLK_W  plaintext
out_valid  out  1  ciphertext available
out_ready  in  1  consumer accepts ciphertext
out_data  out  BLK_W  ciphertext
c_en  out  1  one-cycle start pulse to core `en`
c_rounds_total  out  NR_W  to core `rounds_total`
c_plaintext  out  BLK_W  to core `plaintext`
c_key  out  BLK_W  registered key_mem[c_round_key_no]
c_round_key_no  in  NR_W  from core
c_en_o  in  1  core done
c_ciphertext  in  BLK_W  from core

Behaviour:
- Reset: all outputs 0. State IDLE, key_ready 0, rounds register 0. key_mem contents are not cleared.
- key_mem: KEY_DEPTH x BLK_W. Written on posedge when key_wr_en && state==IDLE && addr<15. Writes in other states are dropped silently.
- Any accepted key write clears key_ready.
- key_cfg_valid in IDLE:
  - latches rounds = key_size ? 14 : 10;
  - sets key_ready next cycle.
  - If key_wr_en and key_cfg_valid are in the same cycle: write done, key_ready ends 1.
- c_key <= key_mem[c_round_key_no] every cycle. Out-of-range index (15) returns 0.
- in_ready = (state==IDLE) && key_ready && !out_valid. Combinational from registers.
- FSM:
  - IDLE: on in_valid && in_ready, register plaintext into c_plaintext, drive c_rounds_total = rounds → START.
  - START: c_en=1 for exactly one cycle → RUN.
  - RUN: wait c_en_o. On the first cycle c_en_o is sampled 1, register out_data <= c_ciphertext, out_valid <= 1 → DONE. Extra c_en_o cycles are ignored.
  - DONE: hold out_data/out_valid until out_valid && out_ready, then out_valid <= 0 → IDLE.
- Latency: input handshake → c_en is 1 cycle. Core done → out_valid is 1 cycle.
- c_plaintext and c_rounds_total are stable from START until return to IDLE.
- Back-to-back: the next block is accepted at the earliest in the cycle after the output handshake. There is one block in flight.
- out_ready held high in DONE: the handshake completes on the first DONE cycle.
- key_cfg_valid outside IDLE: ignored; rounds are unchanged mid-block.
- Reset mid-block: return to IDLE next edge, out_valid 0, c_en 0, key_ready 0. The core is reset by the same reset.

Optional Feature:
AES_CTRL_STATS_EN. When defined, adds these ports:
- blk_count out CNT_W: increments on each output handshake, wraps at 2^CNT_W, reset 0.
- stall_count out CNT_W: increments each DONE cycle with out_ready=0, saturates at all-ones, reset 0.
When undefined, neither the ports nor the logic exist and behaviour is otherwise identical.

Test Plan:
1. Load keys 0..10 with the 128-bit schedule (key0='h0f0e0d0c0b0a09080706050403020100), key_cfg_valid, key_size=0. Plaintext 'hffeeddccbbaa99887766554433221100 → out_data 'h5ac5b47080b7cdd830047b6ad8e0c469; c_rounds_total=10; c_en a single pulse.
2. Load keys 0..14 with the 256-bit schedule (key1='h1f1e1d1c1b1a19181716151413121110), key_size=1, same plaintext → 'h8960494b9049fceabf456751cab7a28e; c_rounds_total=14.
3. Backpressure: out_ready=0 for 20 cycles after out_valid. Required: out_data stable, in_ready=0, a second in_valid is not accepted. Release → handshake, then the next block is accepted and correct.
4. key_wr_en asserted during RUN with garbage data → ignored; result still matches vector 1; key_ready remains 1.
5. Any key write after config → key_ready=0, in_ready=0 with in_valid high until key_cfg_valid re-asserted.
6. Reset asserted 3 cycles into RUN → next cycle busy=0, out_valid=0, key_ready=0. Re-config with the vector-1 keys → vector 1 passes.
